io_port_bank: RTL

//  Memory-mapped I/O register bank for tinymips, directly downstream of the address decoder.

---
 rtl/io_port_bank.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// -----------------------------------------------------------------------------
// io_port_bank -- memory-mapped I/O register bank for tinymips.
//
// Sits directly behind the address decoder and provides:
//   - four output port registers (oport0-3), written by CPU stores
//   - four input ports (iport0-3): 2-flop synchronised, optionally debounced
//   - per-port sticky change flags plus an enable mask that drives irq
//   - combinational read data for the ioport leg of the data-memory read mux
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   ioport_we      [3:0] oport0-3 write strobes, [7:4] iport0-3 control strobes
//   ioport_rd_sel  0-3 selects oport0-3, 4-7 selects debounced iport0-3
//   wd             CPU store data
//   iportN_in      raw asynchronous input ports
//   oportN         output port registers
//   rd_data        combinational read data
//   change         sticky change flags, bit k = iport k
//   irq            |(change & ie)
// -----------------------------------------------------------------------------

// One input lane: synchroniser, debounce counter and accepted value.
module io_iport_lane #(
    parameter int WIDTH    = 32,
    parameter int DEBOUNCE = 0,
    parameter int CNT_W    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic             accept
);
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        // A sample matching the accepted value (a bounce back) restarts the count.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
endmodule

module io_port_bank #(
    parameter int               WIDTH     = 32,
    parameter int               DEBOUNCE  = 0,
    parameter logic [WIDTH-1:0] OPORT_RST = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       ioport_we,
    input  logic [2:0]       ioport_rd_sel,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] iport0_in,
    input  logic [WIDTH-1:0] iport1_in,
    input  logic [WIDTH-1:0] iport2_in,
    input  logic [WIDTH-1:0] iport3_in,
    output logic [WIDTH-1:0] oport0,
    output logic [WIDTH-1:0] oport1,
    output logic [WIDTH-1:0] oport2,
    output logic [WIDTH-1:0] oport3,
    output logic [WIDTH-1:0] rd_data,
    output logic [3:0]       change,
    output logic             irq
);
    localparam int NUM_PORTS = 4;
    localparam int CNT_W     = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

    logic [NUM_PORTS-1:0][WIDTH-1:0] iport_in;
    logic [NUM_PORTS-1:0][WIDTH-1:0] stable;
    logic [NUM_PORTS-1:0]            accept;

    logic [NUM_PORTS-1:0][WIDTH-1:0] oport_q, oport_d;
    logic [NUM_PORTS-1:0]            change_q, change_d;
    logic [NUM_PORTS-1:0]            ie_q, ie_d;

    assign iport_in = {iport3_in, iport2_in, iport1_in, iport0_in};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        io_iport_lane #(
            .WIDTH    (WIDTH),
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (iport_in[g]),
            .stable  (stable[g]),
            .accept  (accept[g])
        );
    end

    // Strobes are handled per register, so a multi-hot decoder fault simply
    // updates every addressed register.
    always_comb begin
        oport_d  = oport_q;
        change_d = change_q;
        ie_d     = ie_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ioport_we[k]) oport_d[k] = wd;
            if (ioport_we[NUM_PORTS+k]) begin
                ie_d[k] = wd[1];
                if (wd[0]) change_d[k] = 1'b0;
            end
            // A new change on the clearing edge must not be lost: set wins.
            if (accept[k]) change_d[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oport_q  <= {NUM_PORTS{OPORT_RST}};
            change_q <= '0;
            ie_q     <= '0;
        end else begin
            oport_q  <= oport_d;
            change_q <= change_d;
            ie_q     <= ie_d;
        end
    end

    always_comb begin
        rd_data = ioport_rd_sel[2] ? stable[ioport_rd_sel[1:0]]
                                   : oport_q[ioport_rd_sel[1:0]];
    end

    assign oport0 = oport_q[0];
    assign oport1 = oport_q[1];
    assign oport2 = oport_q[2];
    assign oport3 = oport_q[3];
    assign change = change_q;
    assign irq    = |(change_q & ie_q);
endmodule
